cordic_batch_sequencer: RTL and testbench
=========================================

// Module: cordic_batch_sequencer
// PURPOSE
//  Parametrised successor to the two-operand CORDIC feeder. Snapshots a batch of up to
//  NUM_OPERANDS targets and issues them into an external CORDIC pipeline, one per enabled
//  cycle. Collects the in-order results into packed output buffers, then pulses done.
//  Sits between the float-front-end adder stage and the cordic_pipeline instance.
// PARAMETERS
//  CORDIC_DATA_WIDTH  22  width of one target/result word
//  FLOAT_DATA_WIDTH   32  width of one squared (float) word
//  NUM_OPERANDS       4   max operands per batch (>=1)
//  CNT_W   $clog2(NUM_OPERANDS+1)  width of num_ops and internal counters (localparam)
//  TIMEOUT_CYCLES     64  watchdog limit, used only with CORDIC_SEQ_TIMEOUT_EN
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst           in   1                  reset, asynchronous, active-low
//  clk_en        in   1                  issue enable; low stalls issue, not result capture
//  start         in   1                  batch request, sampled in IDLE only
//  num_ops       in   CNT_W              batch size, 0..NUM_OPERANDS
//  operands      in   NUM_OPERANDS*CDW   operand k at [k*CDW +: CDW]
//  busy          out  1                  high in every state except IDLE
//  done          out  1                  one-cycle pulse at batch completion
//  error         out  1                  sticky timeout flag (0 without macro)
//  results       out  NUM_OPERANDS*CDW   result k at [k*CDW +: CDW]
//  squares       out  NUM_OPERANDS*FDW   squared k at [k*FDW +: FDW]
//  pipe_target   out  CDW                operand to pipeline (registered)
//  pipe_start    out  1                  operand strobe to pipeline (registered)
//  pipe_result   in   CDW                pipeline result
//  pipe_squared  in   FDW                pipeline squared output
//  pipe_valid    in   1                  pipeline result strobe, in issue order
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. Counters, busy, done, error, pipe_start, pipe_target,
//    results and squares all 0. Reset mid-batch abandons the batch; no done is issued.
//  - FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: start&&clk_en -> snapshot operands and n=min(num_ops,NUM_OPERANDS). Clear
//    issue_cnt and ret_cnt. n==0 -> DONE directly. Otherwise -> ISSUE.
//  - start outside IDLE or with clk_en=0 is ignored, with no queueing.
//  - ISSUE: each cycle with clk_en=1, pipe_start<=1 and pipe_target<=operand[issue_cnt],
//    then issue_cnt++. With clk_en=0, pipe_start<=0 and the operand is held.
//    issue_cnt==n-1 issued -> DRAIN. Start accepted at cycle T gives operand k on the pipe
//    at T+1+k when clk_en stays high.
//  - Capture runs in ISSUE and DRAIN, regardless of clk_en. On pipe_valid:
//    results[ret_cnt]<=pipe_result, squares[ret_cnt]<=pipe_squared, ret_cnt++.
//  - Leave DRAIN for DONE in the cycle after ret_cnt reaches n. Issue and return may occur
//    in the same cycle; both counters update.
//  - pipe_valid in IDLE/DONE, or after ret_cnt==n, is ignored with no buffer write.
//  - DONE: done=1 for exactly one cycle, then IDLE.
//  - results/squares hold their contents until the next accepted batch overwrites them.
//    Slots >= n keep stale values.
//  - busy=1 in ISSUE, DRAIN and DONE.
// CONFIGURATION
//  - CORDIC_SEQ_TIMEOUT_EN defined:
//    - A watchdog counts cycles in DRAIN since the last pipe_valid.
//    - Reaching TIMEOUT_CYCLES sets error=1 (sticky until reset or next accepted start).
//    - It also forces DONE, which pulses done with partial buffers.
//  - Not defined: no watchdog logic; error is tied to 0; DRAIN waits indefinitely.
// TESTING
//  - num_ops=2, operands {0x00100,0x00200}, pipe model latency 5:
//    pipe_start at T+1,T+2 with those targets; done pulses once.
//    results[0]=0x00100 echo, results[1]=0x00200 echo.
//  - num_ops=4, clk_en low on cycles T+2..T+4:
//    issue gaps appear and no operand is skipped or duplicated.
//    All 4 results captured; done fires once.
//  - num_ops=0: done pulses at T+2, no pipe_start, results unchanged.
//  - start asserted during ISSUE plus a stray pipe_valid in IDLE:
//    both are ignored, and the buffers are unchanged.
//  - rst pulled low during DRAIN with 1 of 3 returned:
//    outputs 0 immediately, no done; a following batch completes normally.
//  - CORDIC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, pipe returns 1 of 2:
//    error=1 and done pulse 8 cycles after the last return. error clears on the next start.

Source files
------------

// File: rtl/cordic_batch_sequencer.sv
// Batch sequencer feeding an external CORDIC pipeline and collecting in-order results.
// Optional watchdog enabled by defining CORDIC_SEQ_TIMEOUT_EN.
module cordic_batch_sequencer #(
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int FLOAT_DATA_WIDTH  = 32,
  parameter int NUM_OPERANDS      = 4,
  parameter int TIMEOUT_CYCLES    = 64,
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clk_en,
  input  logic                                      start,
  input  logic [CNT_W-1:0]                          num_ops,
  input  logic [NUM_OPERANDS*CORDIC_DATA_WIDTH-1:0] operands,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  output logic [NUM_OPERANDS*CORDIC_DATA_WIDTH-1:0] results,
  output logic [NUM_OPERANDS*FLOAT_DATA_WIDTH-1:0]  squares,
  output logic [CORDIC_DATA_WIDTH-1:0]              pipe_target,
  output logic                                      pipe_start,
  input  logic [CORDIC_DATA_WIDTH-1:0]              pipe_result,
  input  logic [FLOAT_DATA_WIDTH-1:0]               pipe_squared,
  input  logic                                      pipe_valid
);
  localparam int CDW = CORDIC_DATA_WIDTH;
  localparam int FDW = FLOAT_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        n_q, issue_q, ret_q, n_in;
  logic [NUM_OPERANDS*CDW-1:0] ops_q, res_q;
  logic [NUM_OPERANDS*FDW-1:0] sq_q;
  logic [CDW-1:0]          tgt_q;
  logic                    pstart_q, done_q;
  logic                    accept, issue_en, cap_en, timeout;

  assign n_in = (num_ops > CNT_W'(NUM_OPERANDS))
              ? CNT_W'(NUM_OPERANDS) : num_ops;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    issue_en = 1'b0;
    cap_en   = (state_q == S_ISSUE || state_q == S_DRAIN)
             && pipe_valid && (ret_q < n_q);
    unique case (state_q)
      S_IDLE: begin
        if (start && clk_en) begin
          accept = 1'b1;
          if (n_in == '0)
            state_d = S_DONE;
          else if (n_in == CNT_W'(1))
            state_d = S_DRAIN;
          else
            state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (clk_en) begin
          issue_en = 1'b1;
          if (issue_q == n_q - CNT_W'(1))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_q == n_q || timeout)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Operand 0 leaves on the accepting edge so operand k reaches the pipe k+1 cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q      <= '0;
      issue_q  <= '0;
      ret_q    <= '0;
      ops_q    <= '0;
      res_q    <= '0;
      sq_q     <= '0;
      tgt_q    <= '0;
      pstart_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= (state_q == S_DONE);
      pstart_q <= 1'b0;
      if (accept) begin
        ops_q <= operands;
        n_q   <= n_in;
        ret_q <= '0;
        if (n_in != '0) begin
          pstart_q <= 1'b1;
          tgt_q    <= operands[CDW-1:0];
          issue_q  <= CNT_W'(1);
        end else begin
          issue_q  <= '0;
        end
      end
      if (issue_en) begin
        pstart_q <= 1'b1;
        tgt_q    <= ops_q[issue_q*CDW +: CDW];
        issue_q  <= issue_q + CNT_W'(1);
      end
      if (cap_en) begin
        res_q[ret_q*CDW +: CDW] <= pipe_result;
        sq_q[ret_q*FDW +: FDW]  <= pipe_squared;
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            error_q;

  assign timeout = (state_q == S_DRAIN) && !pipe_valid
                 && (ret_q != n_q)
                 && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q != S_DRAIN || pipe_valid)
        wd_q <= '0;
      else if (!timeout)
        wd_q <= wd_q + WD_W'(1);
      if (accept)
        error_q <= 1'b0;
      else if (timeout)
        error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign results     = res_q;
  assign squares     = sq_q;
  assign pipe_target = tgt_q;
  assign pipe_start  = pstart_q;

endmodule

// File: tb/tb_cordic_batch_sequencer.sv
// Directed bench for cordic_batch_sequencer with a 5-cycle echo pipeline model.
module tb_cordic_batch_sequencer;
  localparam int CDW = 22;
  localparam int FDW = 32;
  localparam int N   = 4;
  localparam int CW  = 3;

  logic clk = 1'b0, rst = 1'b0, clk_en = 1'b0, start = 1'b0;
  logic [CW-1:0]    num_ops = '0;
  logic [N*CDW-1:0] operands = '0;
  logic             busy, done, error, pipe_start, pipe_valid;
  logic [N*CDW-1:0] results;
  logic [N*FDW-1:0] squares;
  logic [CDW-1:0]   pipe_target, pipe_result;
  logic [FDW-1:0]   pipe_squared;

  logic             mute = 1'b0, stray_v = 1'b0;
  logic [CDW-1:0]   stray_r = '0;
  logic [FDW-1:0]   stray_s = '0;
  logic [4:0]       dv = '0;
  logic [5*CDW-1:0] dt = '0;
  logic [CDW-1:0]   dt_out;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dv <= {dv[3:0], pipe_start};
    dt <= {dt[4*CDW-1:0], pipe_target};
  end

  assign dt_out       = dt[5*CDW-1 -: CDW];
  assign pipe_valid   = stray_v | (dv[4] & ~mute);
  assign pipe_result  = stray_v ? stray_r : dt_out;
  assign pipe_squared = stray_v ? stray_s : 32'(dt_out) * 32'(dt_out);

  cordic_batch_sequencer #(
    .CORDIC_DATA_WIDTH(CDW),
    .FLOAT_DATA_WIDTH(FDW),
    .NUM_OPERANDS(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .num_ops(num_ops), .operands(operands),
    .busy(busy), .done(done), .error(error),
    .results(results), .squares(squares),
    .pipe_target(pipe_target), .pipe_start(pipe_start),
    .pipe_result(pipe_result), .pipe_squared(pipe_squared),
    .pipe_valid(pipe_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic window(input int n, output int nd);
    nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
  endtask

  function automatic logic [CDW-1:0] res(input int k);
    return results[k*CDW +: CDW];
  endfunction

  function automatic logic [FDW-1:0] sq(input int k);
    return squares[k*FDW +: FDW];
  endfunction

  initial begin
    int nd, nd2, nps, ok;
    logic [6:0]       mask;
    logic [N*CDW-1:0] seq, res_t2;
    logic [N*FDW-1:0] sq_t2;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pstart", pipe_start, 0);
    chk("rst_ptarget", pipe_target, 0);
    chk("rst_results", results, 0);
    chk("rst_squares", squares, 0);
    rst = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);

    // two operands, back-to-back issue
    num_ops  = 3'd2;
    operands = {22'h4, 22'h3, 22'h200, 22'h100};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_ps0", pipe_start, 1);
    chk("t1_tg0", pipe_target, 22'h100);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_ps1", pipe_start, 1);
    chk("t1_tg1", pipe_target, 22'h200);
    @(negedge clk);
    chk("t1_ps2", pipe_start, 0);
    window(30, nd);
    chk("t1_done", nd, 1);
    chk("t1_res0", res(0), 22'h100);
    chk("t1_res1", res(1), 22'h200);
    chk("t1_sq0", sq(0), 32'h10000);
    chk("t1_sq1", sq(1), 32'h40000);
    chk("t1_idle", busy, 0);

    // four operands with clk_en low on T+2..T+4
    num_ops  = 3'd4;
    operands = {22'h44, 22'h33, 22'h22, 22'h11};
    start    = 1'b1;
    mask = '0;
    seq  = '0;
    nps  = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (pipe_start === 1'b1) begin
        mask[i-1] = 1'b1;
        if (nps < N) seq[nps*CDW +: CDW] = pipe_target;
        nps++;
      end
      clk_en = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
    end
    chk("t2_mask", mask, 7'b1100011);
    chk("t2_nps", nps, 4);
    chk("t2_seq", seq, {22'h44, 22'h33, 22'h22, 22'h11});
    window(30, nd);
    chk("t2_done", nd, 1);
    res_t2 = {22'h44, 22'h33, 22'h22, 22'h11};
    sq_t2  = {32'h1210, 32'hA29, 32'h484, 32'h121};
    chk("t2_results", results, res_t2);
    chk("t2_squares", squares, sq_t2);

    // empty batch
    num_ops = 3'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_done_t1", done, 0);
    chk("t3_busy_t1", busy, 1);
    chk("t3_ps_t1", pipe_start, 0);
    @(negedge clk);
    chk("t3_done_t2", done, 1);
    chk("t3_ps_t2", pipe_start, 0);
    @(negedge clk);
    chk("t3_done_t3", done, 0);
    chk("t3_results", results, res_t2);

    // stray return in IDLE, then start held into ISSUE
    stray_v = 1'b1;
    stray_r = 22'h3FFFF;
    stray_s = 32'hDEAD;
    @(negedge clk);
    stray_v = 1'b0;
    @(negedge clk);
    chk("t4_stray_res", results, res_t2);
    chk("t4_stray_sq", squares, sq_t2);
    num_ops  = 3'd4;
    operands = {22'hA4, 22'hA3, 22'hA2, 22'hA1};
    start    = 1'b1;
    nd  = 0;
    nps = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) begin
        num_ops  = 3'd1;
        operands = {4{22'hBB}};
      end
      if (i == 2) start = 1'b0;
      if (pipe_start === 1'b1) nps++;
      if (done === 1'b1) nd++;
    end
    chk("t4_nps", nps, 4);
    chk("t4_done", nd, 1);
    chk("t4_results", results, {22'hA4, 22'hA3, 22'hA2, 22'hA1});
    chk("t4_squares", squares,
        {32'h6910, 32'h67C9, 32'h6684, 32'h6541});

    // reset in DRAIN after one of three returns
    num_ops  = 3'd3;
    operands = {22'h0, 22'h9, 22'h8, 22'h7};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (pipe_valid === 1'b1) ok = 1;
    end
    chk("t5_first_ret", ok, 1);
    @(posedge clk);
    #1 mute = 1'b1;
    @(negedge clk);
    chk("t5_busy_drain", busy, 1);
    chk("t5_res0_pre", res(0), 22'h7);
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_ps", pipe_start, 0);
    chk("t5_rst_results", results, 0);
    chk("t5_rst_squares", squares, 0);
    window(4, nd);
    rst = 1'b1;
    window(10, nd2);
    chk("t5_no_done", nd + nd2, 0);
    mute     = 1'b0;
    num_ops  = 3'd1;
    operands = {22'h0, 22'h0, 22'h0, 22'h55};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    window(20, nd);
    chk("t5_done", nd, 1);
    chk("t5_res0", res(0), 22'h55);
    chk("t5_sq0", sq(0), 32'h1C39);
    chk("t5_res1_stale", res(1), 0);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    // watchdog: one of two results returns
    num_ops  = 3'd2;
    operands = {22'h0, 22'h0, 22'h2, 22'h1};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (pipe_valid === 1'b1) ok = 1;
    end
    chk("t6_first_ret", ok, 1);
    @(posedge clk);
    #1 mute = 1'b1;
    nd  = 0;
    nd2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        nd2 = int'(error);
      end
    end
    chk("t6_done", nd, 1);
    chk("t6_err_at_done", nd2, 1);
    chk("t6_err_sticky", error, 1);
    chk("t6_res0", res(0), 22'h1);
    mute    = 1'b0;
    num_ops = 3'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_err_clear", error, 0);
    repeat (3) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
